// File: rtl/arm_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arm_issue_pkg
// Description : Shared definitions for the ARM instruction issue stage:
//               instruction field positions, opcode classes, the NOP
//               encoding, issue mode / FSM state enums and small decode
//               helpers for register reads and writes.
// Revision    : 1.0 - initial release
// ============================================================================
package arm_issue_pkg;

  // Instruction field positions
  localparam int COND_HI = 31;
  localparam int COND_LO = 28;
  localparam int OP_HI   = 27;
  localparam int OP_LO   = 26;
  localparam int I_BIT   = 25;
  localparam int CMD_HI  = 24;
  localparam int CMD_LO  = 21;
  localparam int S_BIT   = 20;
  localparam int RN_HI   = 19;
  localparam int RN_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 12;
  localparam int SRC2_HI = 11;
  localparam int SRC2_LO = 0;
  localparam int RM_HI   = 3;
  localparam int RM_LO   = 0;

  // Opcode classes (op field)
  localparam logic [1:0] OPDATA   = 2'b00;
  localparam logic [1:0] OPMEMORY = 2'b01;
  localparam logic [1:0] OPBRANCH = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic {
    FIXED_GAP = 1'b0,
    HAZARD    = 1'b1
  } issue_mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    BUBBLE = 2'd2
  } issue_state_t;

  // Data-processing ops and loads write rd; stores and branches do not.
  function automatic logic writes_rd(input logic [31:0] ins);
    return (ins[OP_HI:OP_LO] == OPDATA) ||
           ((ins[OP_HI:OP_LO] == OPMEMORY) && ins[S_BIT]);
  endfunction

  function automatic logic uses_rn(input logic [31:0] ins);
    return (ins[OP_HI:OP_LO] == OPDATA) || (ins[OP_HI:OP_LO] == OPMEMORY);
  endfunction

  // Register-form data processing reads rm from the low nibble of src2.
  function automatic logic uses_rm(input logic [31:0] ins);
    return (ins[OP_HI:OP_LO] == OPDATA) && !ins[I_BIT];
  endfunction

  // A store reads rd as its data source.
  function automatic logic uses_rd(input logic [31:0] ins);
    return (ins[OP_HI:OP_LO] == OPMEMORY) && !ins[S_BIT];
  endfunction

endpackage
`default_nettype wire

// File: rtl/arm_issue_if.sv
`default_nettype none
// ============================================================================
// Module      : arm_issue_if
// Description : Bus bundle of the issue stage.
//               Producer side : in_valid, in_ready, in_instr, mode, flush
//               Core side     : Instruction, issue_valid
//               Status        : count (FIFO occupancy), stall_cnt
//               master = driver of the producer inputs, slave = issue unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface arm_issue_if #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic              mode;
  logic              flush;
  logic [31:0]       Instruction;
  logic              issue_valid;
  logic [CW-1:0]     count;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output in_valid, in_instr, mode, flush,
    input  in_ready, Instruction, issue_valid, count, stall_cnt
  );

  modport slave (
    input  in_valid, in_instr, mode, flush,
    output in_ready, Instruction, issue_valid, count, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/issue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : issue_fifo
// Description : DEPTH x 32 synchronous FIFO with explicit occupancy count
//               and synchronous flush. Head data is read combinationally.
//               Ports: clk, rst_n (async, active-low), push/pop requests,
//               flush, wdata, rdata (head), count, full, empty.
// Revision    : 1.0 - initial release
// ============================================================================
module issue_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          push,
  input  wire logic          pop,
  input  wire logic          flush,
  input  wire logic [31:0]   wdata,
  output logic      [31:0]   rdata,
  output logic      [CW-1:0] count,
  output logic               full,
  output logic               empty
);
  localparam int AW = $clog2(DEPTH);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push_fire;
  logic          w_pop_fire;

  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign rdata = r_mem[r_rd_ptr];

  // Flush wins over any same-cycle push or pop.
  assign w_push_fire = push && !full  && !flush;
  assign w_pop_fire  = pop  && !empty && !flush;

  always_ff @(posedge clk) begin
    if (w_push_fire) r_mem[r_wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_fire)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_fire, w_pop_fire})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/arm_issue_unit.sv
`default_nettype none
// ============================================================================
// Module      : arm_issue_unit
// Description : Instruction issue stage for the pipelined ARM core. Buffers
//               instructions in a FIFO and issues at most one per cycle,
//               inserting NOP bubbles either as a fixed gap after every
//               instruction or only on register hazards and branches.
//               Ports: clk, reset (async, active-low), bus (arm_issue_if
//               slave: producer handshake, mode, flush, Instruction,
//               issue_valid, count, stall_cnt).
// Revision    : 1.0 - initial release
// ============================================================================
module arm_issue_unit #(
  parameter int DEPTH      = 8,
  parameter int PIPE_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  wire logic  clk,
  input  wire logic  reset,
  arm_issue_if.slave bus
);
  import arm_issue_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(PIPE_DEPTH + 1);

  issue_state_t     r_state;
  logic [GW-1:0]    r_gap;
  logic [31:0]      r_instr;
  logic             r_issue_valid;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [PIPE_DEPTH-1:0] r_sb_valid;
  logic [3:0]       r_sb_rd [PIPE_DEPTH];

  logic [31:0]   w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push_fire;
  logic          w_decide;
  logic          w_hazard;
  logic          w_stall;
  logic          w_pop;
  logic          w_is_branch;
  logic          w_stall_inc;
  issue_mode_t   w_mode;

  issue_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (bus.in_valid),
    .pop   (w_pop),
    .flush (bus.flush),
    .wdata (bus.in_instr),
    .rdata (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_mode      = issue_mode_t'(bus.mode);
  assign w_push_fire = bus.in_valid && !w_full && !bus.flush;
  assign w_is_branch = (w_head[OP_HI:OP_LO] == OPBRANCH);

  // IDLE and ISSUE both evaluate the head, so a push into an idle unit
  // is issued on the very next edge.
  assign w_decide = ((r_state == IDLE) || (r_state == ISSUE)) && !w_empty && !bus.flush;

  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      if (r_sb_valid[i] &&
          ((uses_rn(w_head) && (r_sb_rd[i] == w_head[RN_HI:RN_LO])) ||
           (uses_rm(w_head) && (r_sb_rd[i] == w_head[RM_HI:RM_LO])) ||
           (uses_rd(w_head) && (r_sb_rd[i] == w_head[RD_HI:RD_LO]))))
        w_hazard = 1'b1;
    end
  end

  assign w_stall     = w_decide && (w_mode == HAZARD) && w_hazard;
  assign w_pop       = w_decide && !w_stall;
  assign w_stall_inc = w_stall || ((r_state == BUBBLE) && !w_empty);

  // Scoreboard of in-flight writers; keeps shifting through a flush since
  // those instructions still complete in the core.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sb_valid <= '0;
      for (int i = 0; i < PIPE_DEPTH; i++) r_sb_rd[i] <= '0;
    end else begin
      r_sb_valid[0] <= w_pop && writes_rd(w_head);
      r_sb_rd[0]    <= w_head[RD_HI:RD_LO];
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_sb_valid[i] <= r_sb_valid[i-1];
        r_sb_rd[i]    <= r_sb_rd[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_gap         <= '0;
      r_instr       <= NOP_INSTR;
      r_issue_valid <= 1'b0;
    end else begin
      r_instr       <= NOP_INSTR;
      r_issue_valid <= 1'b0;
      if (bus.flush) begin
        r_state <= IDLE;
        r_gap   <= '0;
      end else begin
        case (r_state)
          IDLE, ISSUE: begin
            if (w_empty) begin
              r_state <= IDLE;
            end else if (w_stall) begin
              r_state <= ISSUE;
            end else begin
              r_instr       <= w_head;
              r_issue_valid <= 1'b1;
              if (w_is_branch || (w_mode == FIXED_GAP)) begin
                r_state <= BUBBLE;
                r_gap   <= GW'(PIPE_DEPTH);
              end else if ((w_count == CW'(1)) && !w_push_fire) begin
                r_state <= IDLE;
              end else begin
                r_state <= ISSUE;
              end
            end
          end
          BUBBLE: begin
            // Last bubble cycle when the gap is about to reach zero.
            if (r_gap <= GW'(1)) begin
              r_gap   <= '0;
              r_state <= w_empty ? IDLE : ISSUE;
            end else begin
              r_gap <= r_gap - 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready    = !w_full;
  assign bus.Instruction = r_instr;
  assign bus.issue_valid = r_issue_valid;
  assign bus.count       = w_count;
  assign bus.stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire
